// File: rtl/serial_adder_pkg.sv
// Shared state encoding for the bit-serial adder.
package serial_adder_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_full_add_cell.sv
// Single-bit full adder used as the serial datapath of serial_adder.
module full_add_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: WIDTH clocks per add through one full-adder cell.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_s, fa_co;

  full_add_cell u_fa (
    .x  (sha_q[0]),
    .y  (shb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state and datapath; result registers move only on the last bit.
  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    psum_d  = psum_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          sha_d   = a;
          shb_d   = b;
          carry_d = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        sha_d   = {1'b0, sha_q[WIDTH-1:1]};
        shb_d   = {1'b0, shb_q[WIDTH-1:1]};
        psum_d  = {fa_s, psum_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        busy_d  = 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = psum_d;
          cout_d  = fa_co;
          // carry into the MSB is the carry register while the MSB is processed
          ovf_d   = carry_q ^ fa_co;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
  assign ovf = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial adder and the additive counterpart of the team's half-subtractor arithmetic cell. Captures two WIDTH-bit operands on a start pulse and adds them LSB-first, one bit per clock, through a single full-adder cell with a registered carry. Presents the parallel sum and carry-out with a one-cycle done strobe. Used where area matters more than latency; the result is checked against the combinational add in the team's arithmetic test drivers.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepted start
b  input  WIDTH  operand B; captured on the accepted start
cin  input  1  carry-in; captured on the accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle strobe; result valid
sum  output  WIDTH  result register; holds last result
cout  output  1  final carry-out; holds with sum

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, counter=0, operand shift registers=0. Asserting rst mid-RUN aborts the operation immediately, with no done strobe and sum/cout forced to 0.
- States: IDLE, RUN, DONE.
- IDLE: when start=1 at edge k:
  - load shA=a, shB=b, carry=cin, counter=0, state=RUN.
  - start=0 keeps the block in IDLE.
- RUN: each edge k+1..k+WIDTH processes one bit:
  - bit s = shA[0]^shB[0]^carry; carry <= majority(shA[0], shB[0], carry).
  - shA and shB shift right; s shifts into the MSB of the partial-sum register; counter++.
  - When counter reaches WIDTH-1 at the edge that processes the last bit: sum <= completed partial sum, cout <= final carry, state=DONE.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Latency: done is high in the cycle following edge k+WIDTH, i.e. WIDTH+1 edges after start is sampled. Throughput is one operation per WIDTH+2 cycles.
- start while in RUN or DONE is ignored. Operands are not re-sampled, and there is no queueing.
- a, b and cin may change freely after capture without affecting the result.
- sum/cout are never updated with partial values. They change only on the DONE transition or on reset.
- busy=1 exactly in RUN; busy and done are never high together.
- Arithmetic is modulo 2^WIDTH on sum, and {cout,sum} equals a+b+cin exactly.

Optional Feature:
Macro SERIAL_ADDER_OVF_EN.
- Defined: adds output ovf (1 bit), which is two's-complement signed overflow. ovf = carry into MSB XOR carry out of MSB, latched on the same edge as sum; reset 0; holds with sum.
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_adder_pkg holds:
  - state typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - localparam for the state width
- Sub-module full_add_cell: purely combinational inputs x, y, ci and outputs s, co. It is instantiated once, fed by shA[0], shB[0] and the carry register.

Test Plan:
- WIDTH=8, a=8'h03, b=8'h05, cin=0, start pulsed -> busy high 8 cycles; done high 9 cycles after start; sum=8'h08, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; previous sum (8'h08) stays stable on the sum port throughout RUN.
- a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start at a=8'h10, b=8'h20; change a/b and pulse start again during RUN -> second start ignored; sum=8'h30, done pulses exactly once.
- Assert rst at RUN cycle 4 -> busy, done, sum, cout go 0 immediately without waiting for clk. After release, a fresh start with a=8'h0A, b=8'h0B -> sum=8'h15.
- With SERIAL_ADDER_OVF_EN: a=8'h7F, b=8'h01 -> sum=8'h80, ovf=1, cout=0; a=8'h80, b=8'h80 -> sum=8'h00, ovf=1, cout=1; a=8'h05, b=8'h03 -> ovf=0.
